// File: rtl/dstage_pkg.sv
// Shared definitions for the decode/issue stage: branch condition codes,
// D/E bubble header, and MD-unit latency / counter sizing helpers.
package dstage_pkg;

   typedef enum logic [2:0] {
      BR_NONE   = 3'd0,
      BR_EQ     = 3'd1,
      BR_NE     = 3'd2,
      BR_LEZ    = 3'd3,
      BR_GTZ    = 3'd4,
      BR_LTZ    = 3'd5,
      BR_GEZ    = 3'd6,
      BR_ALWAYS = 3'd7
   } br_op_e;

   // Width-independent part of the D/E register
   typedef struct packed {
      logic       valid;
      logic       wen;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] a3;
   } de_hdr_t;

   localparam de_hdr_t DE_HDR_BUBBLE = '0;

   function automatic int unsigned md_lat(input logic        is_div,
                                          input int unsigned mult_lat,
                                          input int unsigned div_lat);
      return is_div ? div_lat : mult_lat;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val == 0) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/dstage_fwd_issue_if.sv
// D-stage bus: decoder fields, register-file data, bypass network, D/E
// register outputs and the stat_* ports that exist with or without DSTAGE_STATS_EN.
interface dstage_fwd_issue_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NFWD   = 3,
   parameter int unsigned CTRL_W = 32
);
   logic                 d_valid;
   logic [XLEN-1:0]      d_pc;
   logic [4:0]           d_rs;
   logic [4:0]           d_rt;
   logic [4:0]           d_a3;
   logic                 d_wen;
   logic                 d_use_rs;
   logic                 d_use_rt;
   logic [XLEN-1:0]      d_imm32;
   logic [CTRL_W-1:0]    d_ctrl;
   logic [2:0]           d_br_op;
   logic                 d_md_start;
   logic                 d_md_div;
   logic                 d_md_use;
   logic [XLEN-1:0]      rf_rdata1;
   logic [XLEN-1:0]      rf_rdata2;
   logic [NFWD-1:0]      fwd_wen;
   logic [5*NFWD-1:0]    fwd_a3;
   logic [NFWD-1:0]      fwd_ready;
   logic [XLEN*NFWD-1:0] fwd_data;
   logic                 flush;

   logic                 stall;
   logic                 br_taken;
   logic [XLEN-1:0]      d_v1;
   logic [XLEN-1:0]      d_v2;
   logic                 e_valid;
   logic [XLEN-1:0]      e_pc;
   logic [4:0]           e_rs;
   logic [4:0]           e_rt;
   logic [4:0]           e_a3;
   logic                 e_wen;
   logic [XLEN-1:0]      e_v1;
   logic [XLEN-1:0]      e_v2;
   logic [XLEN-1:0]      e_imm32;
   logic [CTRL_W-1:0]    e_ctrl;
   logic                 md_busy;
   logic [31:0]          stat_stall_cnt;
   logic [31:0]          stat_fwd_cnt;

   modport master (
      output d_valid, d_pc, d_rs, d_rt, d_a3, d_wen, d_use_rs, d_use_rt,
             d_imm32, d_ctrl, d_br_op, d_md_start, d_md_div, d_md_use,
             rf_rdata1, rf_rdata2, fwd_wen, fwd_a3, fwd_ready, fwd_data, flush,
      input  stall, br_taken, d_v1, d_v2, e_valid, e_pc, e_rs, e_rt, e_a3,
             e_wen, e_v1, e_v2, e_imm32, e_ctrl, md_busy,
             stat_stall_cnt, stat_fwd_cnt
   );

   modport slave (
      input  d_valid, d_pc, d_rs, d_rt, d_a3, d_wen, d_use_rs, d_use_rt,
             d_imm32, d_ctrl, d_br_op, d_md_start, d_md_div, d_md_use,
             rf_rdata1, rf_rdata2, fwd_wen, fwd_a3, fwd_ready, fwd_data, flush,
      output stall, br_taken, d_v1, d_v2, e_valid, e_pc, e_rs, e_rt, e_a3,
             e_wen, e_v1, e_v2, e_imm32, e_ctrl, md_busy,
             stat_stall_cnt, stat_fwd_cnt
   );
endinterface

// File: rtl/dstage_fwd_sel.sv
// One operand's bypass path: youngest matching producer wins, falls back to
// register-file data, $0 reads zero, and flags a hazard on unready data.
module dstage_fwd_sel #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NFWD = 3
) (
   input  logic [4:0]           reg_num,
   input  logic [XLEN-1:0]      rf_data,
   input  logic                 use_d,
   input  logic [NFWD-1:0]      fwd_wen,
   input  logic [5*NFWD-1:0]    fwd_a3,
   input  logic [NFWD-1:0]      fwd_ready,
   input  logic [XLEN*NFWD-1:0] fwd_data,
   output logic [XLEN-1:0]      val,
   output logic                 hit,
   output logic                 hazard
);
   logic win_ready;
   logic win_is_e;

   always_comb begin
      hit       = 1'b0;
      win_ready = 1'b1;
      win_is_e  = 1'b0;
      val       = rf_data;
      for (int unsigned i = 0; i < NFWD; i++) begin
         if (!hit && fwd_wen[i] && (fwd_a3[5*i +: 5] == reg_num) && (reg_num != 5'd0)) begin
            hit       = 1'b1;
            val       = fwd_data[XLEN*i +: XLEN];
            win_ready = fwd_ready[i];
            win_is_e  = (i == 0);
         end
      end
      if (reg_num == 5'd0) val = '0;
      // Older producers reach E through the E-stage bypass; only D-use waits on them
      hazard = hit && !win_ready && (use_d || win_is_e);
   end
endmodule

// File: rtl/dstage_fwd_issue.sv
// Decode/issue stage: operand bypass, RAW/MD stall, D-stage branch resolve,
// MD busy counter and the D/E register. Optional counters under DSTAGE_STATS_EN.
module dstage_fwd_issue
   import dstage_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     NFWD     = 3,
   parameter int unsigned     CTRL_W   = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_3000),
   parameter int unsigned     MULT_LAT = 5,
   parameter int unsigned     DIV_LAT  = 10
) (
   input logic               clk,
   input logic               reset,
   dstage_fwd_issue_if.slave bus
);
   localparam int unsigned MD_W = cnt_width(DIV_LAT);

   logic [XLEN-1:0] rs_val, rt_val;
   logic            rs_hit, rt_hit;
   logic            rs_haz, rt_haz;
   logic            stall, issue, cond;
   logic            md_busy;

   logic [MD_W-1:0]   md_cnt_d, md_cnt_q;
   de_hdr_t           e_hdr_d, e_hdr_q;
   logic [XLEN-1:0]   e_pc_d, e_pc_q;
   logic [XLEN-1:0]   e_v1_d, e_v1_q;
   logic [XLEN-1:0]   e_v2_d, e_v2_q;
   logic [XLEN-1:0]   e_imm32_d, e_imm32_q;
   logic [CTRL_W-1:0] e_ctrl_d, e_ctrl_q;

   dstage_fwd_sel #(.XLEN(XLEN), .NFWD(NFWD)) u_rs_sel (
      .reg_num   (bus.d_rs),
      .rf_data   (bus.rf_rdata1),
      .use_d     (bus.d_use_rs),
      .fwd_wen   (bus.fwd_wen),
      .fwd_a3    (bus.fwd_a3),
      .fwd_ready (bus.fwd_ready),
      .fwd_data  (bus.fwd_data),
      .val       (rs_val),
      .hit       (rs_hit),
      .hazard    (rs_haz)
   );

   dstage_fwd_sel #(.XLEN(XLEN), .NFWD(NFWD)) u_rt_sel (
      .reg_num   (bus.d_rt),
      .rf_data   (bus.rf_rdata2),
      .use_d     (bus.d_use_rt),
      .fwd_wen   (bus.fwd_wen),
      .fwd_a3    (bus.fwd_a3),
      .fwd_ready (bus.fwd_ready),
      .fwd_data  (bus.fwd_data),
      .val       (rt_val),
      .hit       (rt_hit),
      .hazard    (rt_haz)
   );

   always_comb begin
      md_busy = (md_cnt_q != '0);
      stall   = bus.d_valid && (rs_haz || rt_haz || (bus.d_md_use && md_busy));
      issue   = bus.d_valid && !stall && !bus.flush;
   end

   always_comb begin
      cond = 1'b0;
      case (br_op_e'(bus.d_br_op))
         BR_NONE:   cond = 1'b0;
         BR_EQ:     cond = (rs_val == rt_val);
         BR_NE:     cond = (rs_val != rt_val);
         BR_LEZ:    cond = ($signed(rs_val) <= $signed(XLEN'(0)));
         BR_GTZ:    cond = ($signed(rs_val) >  $signed(XLEN'(0)));
         BR_LTZ:    cond = ($signed(rs_val) <  $signed(XLEN'(0)));
         BR_GEZ:    cond = ($signed(rs_val) >= $signed(XLEN'(0)));
         BR_ALWAYS: cond = 1'b1;
         default:   cond = 1'b0;
      endcase
   end

   always_comb begin
      md_cnt_d = md_cnt_q;
      if (issue && bus.d_md_start) begin
         md_cnt_d = MD_W'(md_lat(bus.d_md_div, MULT_LAT, DIV_LAT));
      end else if (md_cnt_q != '0) begin
         md_cnt_d = md_cnt_q - MD_W'(1);
      end
   end

   // Bubbles still carry d_pc so EPC tracing sees the stalled/flushed PC
   always_comb begin
      e_hdr_d   = DE_HDR_BUBBLE;
      e_pc_d    = bus.d_pc;
      e_v1_d    = '0;
      e_v2_d    = '0;
      e_imm32_d = '0;
      e_ctrl_d  = '0;
      if (issue) begin
         e_hdr_d.valid = 1'b1;
         e_hdr_d.wen   = bus.d_wen;
         e_hdr_d.rs    = bus.d_rs;
         e_hdr_d.rt    = bus.d_rt;
         e_hdr_d.a3    = bus.d_a3;
         e_v1_d        = rs_val;
         e_v2_d        = rt_val;
         e_imm32_d     = bus.d_imm32;
         e_ctrl_d      = bus.d_ctrl;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt_q  <= '0;
         e_hdr_q   <= DE_HDR_BUBBLE;
         e_pc_q    <= RESET_PC;
         e_v1_q    <= '0;
         e_v2_q    <= '0;
         e_imm32_q <= '0;
         e_ctrl_q  <= '0;
      end else begin
         md_cnt_q  <= md_cnt_d;
         e_hdr_q   <= e_hdr_d;
         e_pc_q    <= e_pc_d;
         e_v1_q    <= e_v1_d;
         e_v2_q    <= e_v2_d;
         e_imm32_q <= e_imm32_d;
         e_ctrl_q  <= e_ctrl_d;
      end
   end

   assign bus.stall    = stall;
   assign bus.br_taken = bus.d_valid && !stall && cond;
   assign bus.d_v1     = rs_val;
   assign bus.d_v2     = rt_val;
   assign bus.md_busy  = md_busy;
   assign bus.e_valid  = e_hdr_q.valid;
   assign bus.e_wen    = e_hdr_q.wen;
   assign bus.e_rs     = e_hdr_q.rs;
   assign bus.e_rt     = e_hdr_q.rt;
   assign bus.e_a3     = e_hdr_q.a3;
   assign bus.e_pc     = e_pc_q;
   assign bus.e_v1     = e_v1_q;
   assign bus.e_v2     = e_v2_q;
   assign bus.e_imm32  = e_imm32_q;
   assign bus.e_ctrl   = e_ctrl_q;

`ifdef DSTAGE_STATS_EN
   logic [31:0] stat_stall_cnt_d, stat_stall_cnt_q;
   logic [31:0] stat_fwd_cnt_d, stat_fwd_cnt_q;

   always_comb begin
      stat_stall_cnt_d = stat_stall_cnt_q;
      stat_fwd_cnt_d   = stat_fwd_cnt_q;
      if (stall && (stat_stall_cnt_q != '1)) stat_stall_cnt_d = stat_stall_cnt_q + 32'd1;
      if (issue && (rs_hit || rt_hit) && (stat_fwd_cnt_q != '1))
         stat_fwd_cnt_d = stat_fwd_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_stall_cnt_q <= '0;
         stat_fwd_cnt_q   <= '0;
      end else begin
         stat_stall_cnt_q <= stat_stall_cnt_d;
         stat_fwd_cnt_q   <= stat_fwd_cnt_d;
      end
   end

   assign bus.stat_stall_cnt = stat_stall_cnt_q;
   assign bus.stat_fwd_cnt   = stat_fwd_cnt_q;
`else
   logic stats_unused;
   assign stats_unused       = rs_hit | rt_hit;
   assign bus.stat_stall_cnt = '0;
   assign bus.stat_fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_dstage_fwd_issue.sv
// Directed bench for dstage_fwd_issue: bypass priority, hazards, branches,
// MD busy window, bubbles, reset and the optional stat counters.
module tb_dstage_fwd_issue;
   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   n;

   always #5 clk = ~clk;

   dstage_fwd_issue_if #(.XLEN(32), .NFWD(3), .CTRL_W(32)) bus ();

   dstage_fwd_issue #(
      .XLEN(32), .NFWD(3), .CTRL_W(32), .RESET_PC(32'h0000_3000),
      .MULT_LAT(5), .DIV_LAT(10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      bus.d_valid = 0; bus.d_pc = '0; bus.d_rs = '0; bus.d_rt = '0; bus.d_a3 = '0;
      bus.d_wen = 0; bus.d_use_rs = 0; bus.d_use_rt = 0; bus.d_imm32 = '0; bus.d_ctrl = '0;
      bus.d_br_op = '0; bus.d_md_start = 0; bus.d_md_div = 0; bus.d_md_use = 0;
      bus.rf_rdata1 = '0; bus.rf_rdata2 = '0; bus.fwd_wen = '0; bus.fwd_a3 = '0;
      bus.fwd_ready = '0; bus.fwd_data = '0; bus.flush = 0;
      tick(); tick();
      check("rst_e_pc", bus.e_pc, 32'h3000);
      check("rst_e_valid", bus.e_valid, 0);
      check("rst_md_busy", bus.md_busy, 0);
      check("rst_e_ctrl", bus.e_ctrl, 0);
      reset = 1'b0;

      // plain register-file operands
      bus.d_valid = 1; bus.d_pc = 32'h3000; bus.d_rs = 5; bus.d_rt = 6; bus.d_a3 = 7;
      bus.d_wen = 1; bus.rf_rdata1 = 32'h1234; bus.rf_rdata2 = 32'h5678;
      bus.d_imm32 = 32'h11; bus.d_ctrl = 32'hC0DE;
      #1;
      check("rf_v1", bus.d_v1, 32'h1234);
      check("rf_v2", bus.d_v2, 32'h5678);
      check("rf_stall", bus.stall, 0);
      check("rf_br_none", bus.br_taken, 0);
      tick();
      check("iss_e_valid", bus.e_valid, 1);
      check("iss_e_v1", bus.e_v1, 32'h1234);
      check("iss_e_v2", bus.e_v2, 32'h5678);
      check("iss_e_pc", bus.e_pc, 32'h3000);
      check("iss_e_a3", bus.e_a3, 7);
      check("iss_e_rs", bus.e_rs, 5);
      check("iss_e_rt", bus.e_rt, 6);
      check("iss_e_wen", bus.e_wen, 1);
      check("iss_e_imm", bus.e_imm32, 32'h11);
      check("iss_e_ctrl", bus.e_ctrl, 32'hC0DE);

      // bypass priority
      bus.fwd_wen = 3'b011; bus.fwd_a3 = {5'd0, 5'd8, 5'd8};
      bus.fwd_data = {32'hC, 32'hB, 32'hA}; bus.fwd_ready = 3'b111; bus.d_rs = 8;
      #1;
      check("prio_src0", bus.d_v1, 32'hA);
      check("prio_stall", bus.stall, 0);
      bus.d_rs = 0; #1;
      check("zero_reg", bus.d_v1, 0);
      bus.d_rs = 8; bus.fwd_wen = 3'b010; #1;
      check("src1_only", bus.d_v1, 32'hB);

      // E-use hazards: older source never stalls, E source does
      bus.d_rs = 5; bus.d_rt = 6; bus.fwd_wen = 3'b010; bus.fwd_a3 = {5'd0, 5'd6, 5'd0};
      bus.fwd_ready = 3'b101; #1;
      check("euse_old_v2", bus.d_v2, 32'hB);
      check("euse_old_stall", bus.stall, 0);
      bus.fwd_wen = 3'b001; bus.fwd_a3 = {5'd0, 5'd0, 5'd6}; bus.fwd_ready = 3'b110; #1;
      check("euse_e_stall", bus.stall, 1);
      check("euse_e_v2", bus.d_v2, 32'hA);

      // branch with D-use on an unready older source
      bus.d_pc = 32'h3040; bus.d_br_op = 3'd1; bus.d_use_rs = 1; bus.d_use_rt = 1;
      bus.d_rs = 9; bus.d_rt = 10; bus.rf_rdata1 = 32'h55; bus.rf_rdata2 = 32'h77;
      bus.fwd_wen = 3'b010; bus.fwd_a3 = {5'd0, 5'd9, 5'd0}; bus.fwd_ready = 3'b101;
      bus.fwd_data = {32'hC, 32'h77, 32'hA};
      #1;
      check("br_stall", bus.stall, 1);
      check("br_taken_stall", bus.br_taken, 0);
      tick();
      check("bub_e_valid", bus.e_valid, 0);
      check("bub_e_pc", bus.e_pc, 32'h3040);
      check("bub_e_v1", bus.e_v1, 0);
      check("bub_e_ctrl", bus.e_ctrl, 0);
      check("bub_e_wen", bus.e_wen, 0);
      bus.fwd_ready = 3'b111; #1;
      check("br_ready_stall", bus.stall, 0);
      check("br_ready_v1", bus.d_v1, 32'h77);
      check("br_eq", bus.br_taken, 1);
      bus.d_br_op = 3'd2; #1; check("br_ne", bus.br_taken, 0);
      bus.d_br_op = 3'd7; #1; check("br_always", bus.br_taken, 1);
      bus.fwd_data = {32'hC, 32'hFFFF_FFF0, 32'hA};
      bus.d_br_op = 3'd5; #1; check("br_ltz_neg", bus.br_taken, 1);
      bus.d_br_op = 3'd4; #1; check("br_gtz_neg", bus.br_taken, 0);
      bus.d_br_op = 3'd3; #1; check("br_lez_neg", bus.br_taken, 1);
      bus.d_br_op = 3'd6; #1; check("br_gez_neg", bus.br_taken, 0);
      bus.d_br_op = 3'd1; #1; check("br_eq_diff", bus.br_taken, 0);
      bus.d_br_op = 3'd0; #1; check("br_none", bus.br_taken, 0);
      bus.d_br_op = 3'd7; #1;
      tick();
      check("br_iss_valid", bus.e_valid, 1);
      check("br_iss_v1", bus.e_v1, 32'hFFFF_FFF0);
      check("br_iss_rs", bus.e_rs, 9);

      // invalid D slot
      bus.d_valid = 0; bus.d_pc = 32'h3080; #1;
      check("inv_br", bus.br_taken, 0);
      check("inv_stall", bus.stall, 0);
      tick();
      check("inv_e_valid", bus.e_valid, 0);
      check("inv_e_pc", bus.e_pc, 32'h3080);

      // div then dependent mfhi
      bus.d_valid = 1; bus.d_br_op = 0; bus.d_use_rs = 0; bus.d_use_rt = 0; bus.fwd_wen = '0;
      bus.d_md_start = 1; bus.d_md_div = 1; bus.d_md_use = 1; bus.d_pc = 32'h30C0; #1;
      check("div_stall", bus.stall, 0);
      tick();
      check("div_busy", bus.md_busy, 1);
      check("div_e_valid", bus.e_valid, 1);
      bus.d_md_start = 0; bus.d_md_div = 0; bus.d_md_use = 1; bus.d_pc = 32'h30C4; #1;
      n = 0;
      while (bus.stall && n < 20) begin n++; tick(); end
      check("mfhi_stall_cycles", n, 10);
      check("mfhi_busy_done", bus.md_busy, 0);
      tick();
      check("mfhi_e_valid", bus.e_valid, 1);
      check("mfhi_e_pc", bus.e_pc, 32'h30C4);

      // mult busy window, counting through idle cycles
      bus.d_md_start = 1; bus.d_md_use = 1; bus.d_pc = 32'h3100;
      tick();
      bus.d_md_start = 0; bus.d_md_use = 0; bus.d_valid = 0;
      n = 0;
      while (bus.md_busy && n < 20) begin n++; tick(); end
      check("mult_busy_cycles", n, 5);

      // flushed div must not start the unit
      bus.d_valid = 1; bus.d_md_start = 1; bus.d_md_div = 1; bus.d_md_use = 1; bus.flush = 1; #1;
      check("flush_div_stall", bus.stall, 0);
      tick();
      check("flush_div_busy", bus.md_busy, 0);
      check("flush_div_e_valid", bus.e_valid, 0);

      // flush and stall together
      bus.d_md_start = 0; bus.d_md_div = 0; bus.d_md_use = 0;
      bus.fwd_wen = 3'b001; bus.fwd_a3 = {5'd0, 5'd0, 5'd9}; bus.fwd_ready = 3'b110;
      bus.d_rs = 9; bus.d_pc = 32'h3200; #1;
      check("fs_stall", bus.stall, 1);
      tick();
      check("fs_e_valid", bus.e_valid, 0);
      check("fs_e_pc", bus.e_pc, 32'h3200);
      check("fs_e_v1", bus.e_v1, 0);
      bus.fwd_wen = '0; bus.d_pc = 32'h3204;
      tick();
      check("flush_e_valid", bus.e_valid, 0);
      check("flush_e_pc", bus.e_pc, 32'h3204);
      bus.flush = 0;

      // reset aborts an MD operation
      bus.d_md_start = 1; bus.d_md_div = 1; bus.d_md_use = 1; bus.d_pc = 32'h3300;
      tick();
      check("rst_mid_busy_pre", bus.md_busy, 1);
      bus.d_md_start = 0; bus.d_md_use = 0; bus.d_valid = 0;
      tick();
      reset = 1;
      tick();
      check("rst_mid_busy", bus.md_busy, 0);
      check("rst_mid_e_pc", bus.e_pc, 32'h3000);
      check("rst_mid_e_valid", bus.e_valid, 0);
      reset = 0;

      // three stall cycles, then two forwarded issues
      bus.d_valid = 1; bus.d_rs = 9; bus.d_use_rs = 0; bus.d_md_use = 0;
      bus.fwd_wen = 3'b001; bus.fwd_a3 = {5'd0, 5'd0, 5'd9}; bus.fwd_ready = 3'b000;
      tick(); tick(); tick();
      bus.fwd_ready = 3'b001;
      tick(); tick();
`ifdef DSTAGE_STATS_EN
      check("stat_stall", bus.stat_stall_cnt, 3);
      check("stat_fwd", bus.stat_fwd_cnt, 2);
`else
      check("stat_stall_tied", bus.stat_stall_cnt, 0);
      check("stat_fwd_tied", bus.stat_fwd_cnt, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
